// File: rtl/shift_right_seq_pkg.sv
// Shared shifter definitions: default widths and the FSM state encoding used by
// the right shifter, the left shifter and the ALU shift decode.
package shift_right_seq_pkg;

  localparam int WIDTH_DEF   = 16;
  localparam int SHAMT_W_DEF = 4;
  localparam int STEP_DEF    = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_right_step.sv
// One right-shift iteration by k (0..STEP), vacated top bits set to fill.
// Combinational, zero latency; no flow control.
module shift_right_step
  import shift_right_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int KW    = 1
) (
  input  logic [WIDTH-1:0] din,
  input  logic [KW-1:0]    k,
  input  logic             fill,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] fill_mask;

  always_comb begin
    // Ones exactly in the k vacated MSB positions when filling with 1.
    fill_mask = fill ? ~({WIDTH{1'b1}} >> k) : '0;
    dout      = (din >> k) | fill_mask;
  end

endmodule

// File: rtl/shift_right_seq.sv
// Iterative SRL/SRA, STEP bits per clock; result ceil(n/STEP) edges after accept.
// Single-entry: in_ready low in SHIFT/DONE, result held in DONE until out_ready.
module shift_right_seq
  import shift_right_seq_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int SHAMT_W = SHAMT_W_DEF,
  parameter int STEP    = STEP_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [SHAMT_W-1:0] shiftAmount,
  input  logic               arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic               busy
);

  localparam int                 KW       = $clog2(STEP + 1);
  localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

  state_t             state;
  logic [SHAMT_W-1:0] rem;
  logic               fill;
  logic [SHAMT_W-1:0] k_amt;
  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   shifted;

  // The last iteration may be shorter than STEP.
  always_comb begin
    k_amt = (rem < STEP_AMT) ? rem : STEP_AMT;
    k     = KW'(k_amt);
  end

  shift_right_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .din  (out),
    .k    (k),
    .fill (fill),
    .dout (shifted)
  );

  assign in_ready = !reset && (state == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      rem       <= '0;
      fill      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            out  <= A;
            rem  <= shiftAmount;
            fill <= arith & A[WIDTH-1];
            busy <= 1'b1;
            if (shiftAmount == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          out <= shifted;
          rem <= rem - k_amt;
          if (rem == k_amt) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: a STEP=1 instance (index 0) and a STEP=4 instance
// (index 1) share operand inputs; expected results flow through per-instance queues.
module tb_shift_right_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_valid;
  wire  [1:0]  in_ready;
  logic [15:0] A;
  logic [3:0]  shiftAmount;
  logic        arith;
  logic        out_ready;
  wire  [1:0]  out_valid;
  wire  [1:0]  busy;
  logic [15:0] out0, out1;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  shift_right_seq #(.WIDTH(16), .SHAMT_W(4), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .A(A), .shiftAmount(shiftAmount), .arith(arith),
    .out_valid(out_valid[0]), .out_ready(out_ready), .out(out0), .busy(busy[0])
  );

  shift_right_seq #(.WIDTH(16), .SHAMT_W(4), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .A(A), .shiftAmount(shiftAmount), .arith(arith),
    .out_valid(out_valid[1]), .out_ready(out_ready), .out(out1), .busy(busy[1])
  );

  function automatic logic [15:0] model(input logic [15:0] a, input logic [3:0] n, input logic ar);
    logic signed [15:0] s;
    if (ar) begin
      s = a;
      s = s >>> n;
      return s;
    end
    return a >> n;
  endfunction

  function automatic logic [15:0] dout(input int sel);
    return (sel == 1) ? out1 : out0;
  endfunction

  // Present a request and hold it until the instance takes it; queue the expected result.
  task automatic accept(input int sel, input logic [15:0] a, input logic [3:0] n,
                        input logic ar, input logic [15:0] exp, output bit ok);
    A = a; shiftAmount = n; arith = ar;
    in_valid[sel] = 1'b1;
    for (int t = 0; t < 50 && !in_ready[sel]; t++) begin
      @(posedge clk); #1;
    end
    ok = in_ready[sel];
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    if (ok) begin
      if (sel == 1) q1.push_back(exp);
      else          q0.push_back(exp);
    end
  endtask

  task automatic wait_out(input int sel, output int lat, output bit ok);
    lat = 0;
    while (!out_valid[sel] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    ok = out_valid[sel];
  endtask

  task automatic sb_pop(input int sel, output logic [15:0] e, output bit have);
    have = 1'b0;
    e = '0;
    if (sel == 1) begin
      if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    end else begin
      if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = '0; out_ready = 1'b1;
    A = '0; shiftAmount = '0; arith = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (dout(s) !== 16'h0 || out_valid[s] !== 1'b0 || busy[s] !== 1'b0 || in_ready[s] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state[%0d]: out=%h ov=%b busy=%b ir=%b expected 0000 0 0 0",
                 s, dout(s), out_valid[s], busy[s], in_ready[s]);
      end
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_release_in_ready: got %b expected 11", in_ready);
    end
  endtask

  task automatic test_srl();
    bit ok; int lat; bit bz; logic [15:0] e; bit have;
    accept(0, 16'hF000, 4'd4, 1'b0, 16'h0F00, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL srl_accept: in_ready=%b expected 1", in_ready[0]); end
    bz = 1'b1; lat = 0;
    while (!out_valid[0] && lat < 40) begin
      bz &= busy[0];
      @(posedge clk); #1;
      lat++;
    end
    bz &= busy[0];
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL srl_latency: got %0d edges expected 4", lat); end
    n_checks++;
    if (!bz) begin n_fail++; $display("FAIL srl_busy: busy dropped while operation in flight, expected 1"); end
    sb_pop(0, e, have);
    n_checks++;
    if (!have || out0 !== e) begin n_fail++; $display("FAIL srl_data: got %h expected %h", out0, e); end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL srl_return_idle: ov=%b busy=%b ir=%b expected 0 0 1", out_valid[0], busy[0], in_ready[0]);
    end
  endtask

  task automatic test_full_shift();
    bit ok; int lat; logic [15:0] e; bit have;
    logic [15:0] exps [2];
    exps[0] = 16'h0001;
    exps[1] = 16'hFFFF;
    for (int ar = 0; ar < 2; ar++) begin
      accept(0, 16'h8000, 4'd15, ar[0], exps[ar], ok);
      wait_out(0, lat, ok);
      n_checks++;
      if (!ok || lat != 15) begin n_fail++; $display("FAIL full_latency[ar=%0d]: got %0d edges expected 15", ar, lat); end
      sb_pop(0, e, have);
      n_checks++;
      if (!have || out0 !== e) begin n_fail++; $display("FAIL full_data[ar=%0d]: got %h expected %h", ar, out0, e); end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
        n_fail++; $display("FAIL full_return_idle[ar=%0d]: ov=%b ir=%b expected 0 1", ar, out_valid[0], in_ready[0]);
      end
    end
  endtask

  task automatic test_step4();
    bit ok; int lat; logic [15:0] e; bit have;
    logic [15:0] av [2];
    logic [3:0]  nv [2];
    logic        arv [2];
    logic [15:0] ev [2];
    int          lv [2];
    av[0] = 16'h1234; nv[0] = 4'd7; arv[0] = 1'b0; ev[0] = 16'h0024; lv[0] = 2;
    av[1] = 16'hC000; nv[1] = 4'd2; arv[1] = 1'b1; ev[1] = 16'hF000; lv[1] = 1;
    for (int i = 0; i < 2; i++) begin
      accept(1, av[i], nv[i], arv[i], ev[i], ok);
      wait_out(1, lat, ok);
      n_checks++;
      if (!ok || lat != lv[i]) begin n_fail++; $display("FAIL step4_latency[%0d]: got %0d edges expected %0d", i, lat, lv[i]); end
      sb_pop(1, e, have);
      n_checks++;
      if (!have || out1 !== e) begin n_fail++; $display("FAIL step4_data[%0d]: got %h expected %h", i, out1, e); end
      @(posedge clk); #1;
      n_checks++;
      if (out_valid[1] !== 1'b0 || in_ready[1] !== 1'b1) begin
        n_fail++; $display("FAIL step4_return_idle[%0d]: ov=%b ir=%b expected 0 1", i, out_valid[1], in_ready[1]);
      end
    end
  endtask

  task automatic test_zero_shift();
    bit ok; int lat; logic [15:0] e; bit have;
    for (int s = 0; s < 2; s++) begin
      accept(s, 16'hA5A5, 4'd0, 1'b1, 16'hA5A5, ok);
      wait_out(s, lat, ok);
      n_checks++;
      if (!ok || lat != 0) begin n_fail++; $display("FAIL zero_latency[%0d]: got %0d extra edges expected 0", s, lat); end
      sb_pop(s, e, have);
      n_checks++;
      if (!have || dout(s) !== e) begin n_fail++; $display("FAIL zero_data[%0d]: got %h expected %h", s, dout(s), e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    bit ok; int lat; logic [15:0] e; bit have; logic [15:0] snap; bit stable;
    out_ready = 1'b0;
    accept(0, 16'h1234, 4'd3, 1'b0, 16'h0246, ok);
    wait_out(0, lat, ok);
    n_checks++;
    if (!ok || lat != 3) begin n_fail++; $display("FAIL bp_latency: got %0d edges expected 3", lat); end
    snap = out0;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        A = 16'hFFFF; shiftAmount = 4'd1; arith = 1'b1;
        in_valid[0] = 1'b1;
      end
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      if (out_valid[0] !== 1'b1 || out0 !== snap || in_ready[0] !== 1'b0 || busy[0] !== 1'b1) stable = 1'b0;
    end
    n_checks++;
    if (!stable) begin n_fail++; $display("FAIL bp_hold: output or flags changed under stall, out=%h expected %h", out0, snap); end
    sb_pop(0, e, have);
    n_checks++;
    if (!have || out0 !== e) begin n_fail++; $display("FAIL bp_data: got %h expected %h", out0, e); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: ov=%b busy=%b ir=%b expected 0 0 1", out_valid[0], busy[0], in_ready[0]);
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL bp_dropped_request: ov=%b busy=%b expected 0 0", out_valid[0], busy[0]);
    end
  endtask

  task automatic test_reset_mid_shift();
    bit ok; int lat; logic [15:0] e; bit have;
    accept(0, 16'h8001, 4'd10, 1'b1, model(16'h8001, 4'd10, 1'b1), ok);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out0 !== 16'h0 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
      n_fail++; $display("FAIL midreset_state: out=%h ov=%b busy=%b ir=%b expected 0000 0 0 0",
                         out0, out_valid[0], busy[0], in_ready[0]);
    end
    reset = 1'b0;
    q0.delete();
    repeat (12) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
      n_fail++; $display("FAIL midreset_no_output: ov=%b ir=%b expected 0 1", out_valid[0], in_ready[0]);
    end
    accept(0, 16'h8000, 4'd5, 1'b1, 16'hFC00, ok);
    wait_out(0, lat, ok);
    n_checks++;
    if (!ok || lat != 5) begin n_fail++; $display("FAIL midreset_next_latency: got %0d edges expected 5", lat); end
    sb_pop(0, e, have);
    n_checks++;
    if (!have || out0 !== e) begin n_fail++; $display("FAIL midreset_next_data: got %h expected %h", out0, e); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    bit ok; int lat; logic [15:0] e; bit have;
    logic [15:0] a; int n; logic ar; int step; int bad;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      int s;
      s = i % 2;
      step = (s == 1) ? 4 : 1;
      a = 16'($urandom);
      n = $urandom_range(0, 15);
      ar = 1'($urandom_range(0, 1));
      accept(s, a, 4'(n), ar, model(a, 4'(n), ar), ok);
      wait_out(s, lat, ok);
      n_checks++;
      if (!ok || lat != (n + step - 1) / step) begin
        n_fail++; $display("FAIL b2b_latency[%0d]: got %0d edges expected %0d", i, lat, (n + step - 1) / step);
      end
      sb_pop(s, e, have);
      n_checks++;
      if (!have || dout(s) !== e) begin
        n_fail++; $display("FAIL b2b_data[%0d]: A=%h n=%0d ar=%b got %h expected %h", i, a, n, ar, dout(s), e);
      end
      @(posedge clk); #1;
      if (out_valid[s] !== 1'b0 || in_ready[s] !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL b2b_return_idle: %0d ops not idle after handshake, expected 0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_srl();
    test_full_shift();
    test_step4();
    test_zero_shift();
    test_backpressure();
    test_reset_mid_shift();
    test_back_to_back();
    n_checks++;
    if (q0.size() + q1.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", q0.size() + q1.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
